// File: rtl/pwm_ramp_ctrl_if.sv
// Ramp command handshake between the CPU register file and pwm_ramp_ctrl.
//   cmd_valid  : command present (master -> slave)
//   cmd_ready  : command accepted when valid & ready (slave -> master)
//   cmd_target : target cmp value, 27b
//   cmd_step   : cmp change per ramp step, 27b (0 means 1)
//   cmd_hold   : PWM periods per ramp step, HOLD_W bits (0 means 1)
interface pwm_ramp_ctrl_if #(
   parameter int unsigned HOLD_W = 16
) ();
   logic              cmd_valid;
   logic              cmd_ready;
   logic [26:0]       cmd_target;
   logic [26:0]       cmd_step;
   logic [HOLD_W-1:0] cmd_hold;

   modport master (output cmd_valid, cmd_target, cmd_step, cmd_hold, input cmd_ready);
   modport slave  (input cmd_valid, cmd_target, cmd_step, cmd_hold, output cmd_ready);
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: sequencer for the 27-bit PWM timer. Drives the timer's top_in/cmp_in
// words and ramps cmp from its current value to a commanded target in fixed steps, one
// step every cmd_hold PWM periods. An internal mirror of the timer counter makes cmp
// updates land on period boundaries.
// Ports:
//   CLK, RST   : clock shared with the timer; synchronous active-high reset
//   en         : timer enable request
//   top_cfg    : period top (period = top+1 cycles), sampled only while idle
//   cmd        : ramp command handshake (pwm_ramp_ctrl_if.slave)
//   top_out    : {en_q, 4'b0, top_q} to timer top_in
//   cmp_out    : {5'b0, cmp_q} to timer cmp_in
//   busy       : ramp in progress
//   done       : one-cycle pulse on the cycle cmp reaches target
// Build option: define PWM_RAMP_RETARGET_EN to accept new commands during a ramp.
module pwm_ramp_ctrl #(
   parameter int unsigned HOLD_W = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 en,
   input  logic [26:0]          top_cfg,
   pwm_ramp_ctrl_if.slave       cmd,
   output logic [31:0]          top_out,
   output logic [31:0]          cmp_out,
   output logic                 busy,
   output logic                 done
);
   localparam int unsigned CW = 27;

   typedef enum logic [0:0] {IDLE = 1'b0, RAMP = 1'b1} state_t;

   state_t            state, state_n;
   logic              en_q;
   logic [CW-1:0]     top_q, cnt_q, cmp_q, tgt_q, step_q;
   logic [HOLD_W-1:0] hold_q, pcnt_q;
   logic              ready_q;

   logic [CW-1:0]     cmp_n, tgt_n, step_n;
   logic [HOLD_W-1:0] hold_n, pcnt_n;
   logic              done_n, ready_n;

   logic              wrap, accept, up;
   logic [CW:0]       top_p1;
   logic [CW-1:0]     tgt_c, step_c, diff;
   logic [HOLD_W-1:0] hold_c;

   // Period boundary: last cycle of the timer period, timer sees the new cmp at cnt==0.
   assign wrap   = en_q && (cnt_q >= top_q);
   assign accept = cmd.cmd_valid && ready_q;

   // Target clamp to top+1 (100% duty); min() keeps the result within 27 bits.
   assign top_p1 = {1'b0, top_q} + (CW+1)'(1);
   assign tgt_c  = ({1'b0, cmd.cmd_target} > top_p1) ? top_p1[CW-1:0] : cmd.cmd_target;
   assign step_c = (cmd.cmd_step == '0) ? CW'(1) : cmd.cmd_step;
   assign hold_c = (cmd.cmd_hold == '0) ? HOLD_W'(1) : cmd.cmd_hold;

   assign up   = tgt_q > cmp_q;
   assign diff = up ? (tgt_q - cmp_q) : (cmp_q - tgt_q);

   // Timer-side registers and counter mirror.
   always_ff @(posedge CLK) begin
      if (RST) begin
         en_q  <= 1'b0;
         top_q <= '0;
         cnt_q <= '0;
      end else begin
         en_q <= en;
         if (state == IDLE) top_q <= top_cfg;
         if (!en_q || cnt_q >= top_q) cnt_q <= '0;
         else                         cnt_q <= cnt_q + CW'(1);
      end
   end

   // State register and ramp datapath registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         cmp_q   <= '0;
         tgt_q   <= '0;
         step_q  <= CW'(1);
         hold_q  <= HOLD_W'(1);
         pcnt_q  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state   <= state_n;
         cmp_q   <= cmp_n;
         tgt_q   <= tgt_n;
         step_q  <= step_n;
         hold_q  <= hold_n;
         pcnt_q  <= pcnt_n;
         busy    <= (state_n == RAMP);
         done    <= done_n;
         ready_q <= ready_n;
      end
   end

   // Next-state and datapath decode.
   always_comb begin
      state_n = state;
      cmp_n   = cmp_q;
      tgt_n   = tgt_q;
      step_n  = step_q;
      hold_n  = hold_q;
      pcnt_n  = pcnt_q;
      done_n  = 1'b0;
      ready_n = 1'b1;

      case (state)
         IDLE: begin
            if (accept) begin
               tgt_n  = tgt_c;
               step_n = step_c;
               hold_n = hold_c;
               pcnt_n = '0;
               if (tgt_c == cmp_q) done_n  = 1'b1;
               else                state_n = RAMP;
            end
         end
         RAMP: begin
            if (wrap) begin
               if (pcnt_q == hold_q - HOLD_W'(1)) begin
                  pcnt_n = '0;
                  if (diff <= step_q) begin
                     cmp_n   = tgt_q;
                     done_n  = 1'b1;
                     state_n = IDLE;
                  end else begin
                     cmp_n = up ? (cmp_q + step_q) : (cmp_q - step_q);
                  end
               end else begin
                  pcnt_n = pcnt_q + HOLD_W'(1);
               end
            end
`ifdef PWM_RAMP_RETARGET_EN
            // Any step due this cycle is applied first; the new command then supersedes.
            if (accept) begin
               tgt_n  = tgt_c;
               step_n = step_c;
               hold_n = hold_c;
               pcnt_n = '0;
               if (tgt_c == cmp_n) begin
                  done_n  = 1'b1;
                  state_n = IDLE;
               end else begin
                  done_n  = 1'b0;
                  state_n = RAMP;
               end
            end
`endif
         end
         default: state_n = IDLE;
      endcase

`ifndef PWM_RAMP_RETARGET_EN
      ready_n = (state_n == IDLE);
`endif
   end

   assign cmd.cmd_ready = ready_q;
   assign top_out       = {en_q, 4'b0000, top_q};
   assign cmp_out       = {5'b00000, cmp_q};
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Scoreboard bench for pwm_ramp_ctrl: each command pushes its hand-computed cmp/done
// sequence; a monitor pops one entry per observed cmp change or done pulse.
module tb_pwm_ramp_ctrl;
   localparam int unsigned HOLD_W = 16;
   localparam int          TMO    = 3000;

   logic        CLK = 1'b0;
   logic        RST;
   logic        en;
   logic [26:0] top_cfg;
   logic [31:0] top_out, cmp_out;
   logic        busy, done;

   pwm_ramp_ctrl_if #(.HOLD_W(HOLD_W)) cmd_bus ();

   pwm_ramp_ctrl #(.HOLD_W(HOLD_W)) dut (
      .CLK     (CLK),
      .RST     (RST),
      .en      (en),
      .top_cfg (top_cfg),
      .cmd     (cmd_bus),
      .top_out (top_out),
      .cmp_out (cmp_out),
      .busy    (busy),
      .done    (done)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int value;
      bit dn;
      int gap;   // cycles since previous event; -1 = not checked
   } ev_t;

   ev_t sb[$];
   ev_t ev;
   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   int  last_cyc = 0;
   logic [26:0] prev_cmp = '0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic push(input int v, input bit d, input int g);
      ev_t e;
      e.value = v;
      e.dn    = d;
      e.gap   = g;
      sb.push_back(e);
   endtask

   // Monitor: every cmp change or done pulse consumes one expected event.
   always @(negedge CLK) begin
      cyc++;
      if (cmp_out[26:0] != prev_cmp || done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event cmp=%0d done=%0d required=none", cmp_out[26:0], done);
         end else begin
            ev = sb.pop_front();
            check("ev_cmp", cmp_out[26:0], ev.value);
            check("ev_done", done, ev.dn);
            check("ev_cmp_hi", cmp_out[31:27], 0);
            if (ev.gap >= 0) check("ev_gap", cyc - last_cyc, ev.gap);
            if (done) check("busy_at_done", busy, 0);
         end
         prev_cmp = cmp_out[26:0];
         last_cyc = cyc;
      end
   end

   task automatic send(input int tgt, input int st, input int hd, input bit exp_busy);
      int t;
      @(negedge CLK);
      cmd_bus.cmd_valid  = 1'b1;
      cmd_bus.cmd_target = 27'(tgt);
      cmd_bus.cmd_step   = 27'(st);
      cmd_bus.cmd_hold   = HOLD_W'(hd);
      t = 0;
      while (!cmd_bus.cmd_ready && t < TMO) begin
         @(negedge CLK);
         t++;
      end
      if (t >= TMO) begin
         checks++;
         errors++;
         $display("FAIL cmd_accept_timeout actual=%0d required<%0d", t, TMO);
      end
      @(negedge CLK);
      cmd_bus.cmd_valid = 1'b0;
      check("busy_after_accept", busy, exp_busy);
   endtask

   task automatic wait_val(input int v);
      int t;
      t = 0;
      while (cmp_out[26:0] != 27'(v) && t < TMO) begin
         @(negedge CLK);
         t++;
      end
      if (t >= TMO) begin
         checks++;
         errors++;
         $display("FAIL wait_cmp_timeout actual=%0d required=%0d", cmp_out[26:0], v);
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < TMO) begin
         @(negedge CLK);
         t++;
      end
      if (t >= TMO) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout actual=%0d required=0 pending", sb.size());
         sb.delete();
      end
      repeat (3) @(negedge CLK);
   endtask

   initial begin
      RST                = 1'b1;
      en                 = 1'b0;
      top_cfg            = 27'd9;
      cmd_bus.cmd_valid  = 1'b0;
      cmd_bus.cmd_target = '0;
      cmd_bus.cmd_step   = '0;
      cmd_bus.cmd_hold   = '0;
      repeat (3) @(negedge CLK);
      check("rst_top_out", top_out, 0);
      check("rst_cmp_out", cmp_out, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ready", cmd_bus.cmd_ready, 1);
      RST = 1'b0;
      en  = 1'b1;
      repeat (5) @(negedge CLK);
      check("top_out_idle", top_out, 32'h8000_0009);

      // 1: 0 -> 5, step 1, hold 1: one step per 10-cycle period
      push(1, 0, -1); push(2, 0, 10); push(3, 0, 10); push(4, 0, 10); push(5, 1, 10);
      send(5, 1, 1, 1);
      drain();
      check("t1_busy_end", busy, 0);

      // back to 0 in one step, then 2: step 3, hold 2 -> 3,6,7
      push(0, 1, -1);
      send(0, 5, 1, 1);
      drain();
      push(3, 0, -1); push(6, 0, 20); push(7, 1, 20);
      send(7, 3, 2, 1);
      drain();

      // 3: target 50 clamps to top+1 = 10; then down ramp step 4 -> 6,2,0
      push(10, 1, -1);
      send(50, 3, 1, 1);
      drain();
      check("t3_cmp_full", cmp_out, 10);
      push(6, 0, -1); push(2, 0, 10); push(0, 1, 10);
      send(0, 4, 1, 1);
      drain();

      // 4: en dropped 30 cycles at cmp 2; ramp freezes and resumes, same step count
      push(1, 0, -1); push(2, 0, 10); push(3, 0, -1); push(4, 0, 10); push(5, 0, 10);
      push(6, 1, 10);
      send(6, 1, 1, 1);
      wait_val(2);
      en = 1'b0;
      repeat (30) @(negedge CLK);
      check("t4_frozen_cmp", cmp_out, 2);
      check("t4_en_q", top_out[31], 0);
      check("t4_busy", busy, 1);
      en = 1'b1;
      drain();

      // 5: reset at cmp 4 mid-ramp: everything back to reset values, no done
      push(5, 0, -1); push(4, 0, 10); push(0, 0, -1);
      send(0, 1, 1, 1);
      wait_val(4);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      check("t5_top_out", top_out, 0);
      check("t5_cmp_out", cmp_out, 0);
      check("t5_busy", busy, 0);
      check("t5_done", done, 0);
      check("t5_ready", cmd_bus.cmd_ready, 1);
      drain();

      // target equal to current cmp: immediate done, no ramp
      push(0, 1, -1);
      send(0, 1, 1, 0);
      drain();

      // 6: command issued while ramping
      push(1, 0, -1); push(2, 0, 10);
`ifdef PWM_RAMP_RETARGET_EN
      push(1, 1, 10);
`else
      push(3, 0, 10); push(4, 1, 10); push(3, 0, -1); push(2, 0, 10); push(1, 1, 10);
`endif
      send(4, 1, 1, 1);
      wait_val(2);
`ifdef PWM_RAMP_RETARGET_EN
      check("t6_ready_in_ramp", cmd_bus.cmd_ready, 1);
`else
      check("t6_ready_in_ramp", cmd_bus.cmd_ready, 0);
`endif
      send(1, 1, 1, 1);
      drain();
      check("t6_final_cmp", cmp_out, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
